video_format_scheduler: RTL and testbench
=========================================

# video_format_scheduler

Measurement-and-configuration controller for the BKM-68X video input path. It runs repeating gated measurement windows on the incoming vsync/hsync and classifies the result as 576i50, 480i60, 576p50, 480p60 or none. A new format is committed only after it has been seen in several consecutive windows. Each committed change goes to the downstream video-path configuration logic over a req/ack handshake. The block sits between the sync input pins and the mode-configuration logic, and replaces free-running, unsynchronized format sampling.

## Interface

Parameters:
- GATE_CYCLES, 50000000: measurement window length in clk_50mhz_in cycles (1 s).
- STABLE_COUNT, 3: consecutive identical classifications required before commit (1..15).
- ACK_TIMEOUT, 1000000: cycles to wait for cfg_ack before flagging an error.
- V50_MIN / V50_MAX, 45 / 55: inclusive vsync-per-gate range for 50 Hz.
- V60_MIN / V60_MAX, 56 / 65: inclusive vsync-per-gate range for 60 Hz.
- H_INTERLACE_MAX, 23000: hsync-per-gate count at or below which the format is interlaced.

Ports:
- clk_50mhz_in, in, 1: system clock.
- reset, in, 1: asynchronous, active-low.
- vsync_in, in, 1: asynchronous vertical sync, active-low pulse.
- hsync_in, in, 1: asynchronous horizontal sync, active-low pulse.
- measure_en, in, 1: high enables measurement. Low forces IDLE.
- cfg_ack, in, 1: level acknowledge from downstream config logic.
- cfg_req, out, 1: configuration request.
- cfg_format, out, 8: format code offered with cfg_req.
- format_out, out, 8: committed format (0x00 none, 0x01 576i50, 0x02 480i60, 0x03 576p50, 0x04 480p60).
- locked, out, 1: format_out is nonzero and the last STABLE_COUNT classifications matched it.
- error_bits, out, 5: status flags, see Operation.

## Operation

Input conditioning:
- vsync_in and hsync_in each pass through a 2-FF synchronizer, then a falling-edge detector.
- Result is a 1-cycle edge pulse, 3 clocks after the pin edge.

FSM states:
- IDLE: all counters cleared, cfg_req low. Goes to ARM when measure_en is high.
- ARM: waits for a vsync edge so windows align to a field boundary.
  - On the edge: go to GATE. That edge is not counted.
  - If no edge arrives within GATE_CYCLES: go to EVAL with vsync count = 0.
- GATE: counts vsync and hsync edges in 16-bit counters for exactly GATE_CYCLES cycles, then goes to EVAL.
  - An edge on the final GATE cycle is counted.
  - Counters saturate at 0xFFFF and set error_bits[4].
- EVAL (1 cycle): classify, update the stability counter, then decide the next state.
  - Go to CONFIG if the candidate is stable, differs from format_out, and cfg_ack is low.
  - Otherwise go to ARM.

Classification (applied in EVAL):
- Rate is 50 if V50_MIN ≤ vcnt ≤ V50_MAX. Rate is 60 if V60_MIN ≤ vcnt ≤ V60_MAX. Otherwise the rate is invalid and the candidate is 0x00.
- interlaced = (hcnt ≤ H_INTERLACE_MAX).
- Codes: 50 + interlaced → 0x01, 60 + interlaced → 0x02, 50 + progressive → 0x03, 60 + progressive → 0x04.
- hcnt = 0 with a valid rate gives candidate 0x00.

Stability:
- 4-bit counter. Increments (saturating at STABLE_COUNT) when the candidate equals the previous candidate; otherwise reloads to 1.
- The candidate is stable when the counter equals STABLE_COUNT.

CONFIG handshake:
- cfg_req goes high with cfg_format set to the candidate. cfg_format holds while cfg_req is high.
- On the first cycle cfg_ack is sampled high: format_out ← cfg_format, cfg_req drops next cycle, go to ARM.
- If ACK_TIMEOUT cycles pass without ack: drop cfg_req, set error_bits[3], leave format_out unchanged, go to ARM. The commit is retried on the next stable EVAL.

error_bits:
- [0] no vsync in last window.
- [1] vsync rate out of range (nonzero).
- [2] hsync count zero with valid vsync rate.
- [3] ack timeout.
- [4] counter saturation.
- Bits 0–2 are rewritten every EVAL.
- Bits 3–4 are sticky, cleared only by reset or by measure_en going low.

## Timing

- Reset values: cfg_req 0, cfg_format 0x00, format_out 0x00, locked 0, error_bits 0, FSM IDLE, all counters 0.
- measure_en low in any state: IDLE on the next clock, cfg_req low on the next clock. format_out and locked keep their values; the stability counter clears.
- Reset asserted mid-window or mid-handshake: all state returns to reset values immediately (asynchronous).
- Minimum time from first aligned vsync to format_out update: STABLE_COUNT × (GATE_CYCLES + 1 EVAL + ARM wait) + ack latency + 1 cycle.
- locked updates in the same cycle as EVAL results and format_out.
- cfg_format never changes while cfg_req is high.

## Test plan

1. Reset, measure_en=1, 50 Hz vsync with 15625 Hz hsync, ack returned 2 cycles after req → after 3 gates: cfg_req pulse with cfg_format=0x01, format_out=0x01, locked=1, error_bits=0.
2. Switch to 60 Hz / 31469 Hz hsync → locked drops at the next EVAL. After 3 gates: cfg_format=0x04, then format_out=0x04 and locked=1.
3. Alternate 50 Hz and 60 Hz per window → stability counter never reaches 3, no cfg_req, format_out unchanged.
4. Remove vsync entirely → ARM times out, error_bits[0]=1. After 3 windows: commit of 0x00, locked=0.
5. Stable 576p50, cfg_ack held low → cfg_req high for exactly ACK_TIMEOUT cycles, then drops, error_bits[3]=1, format_out unchanged. Request is retried at the next stable EVAL.
6. Drop measure_en mid-GATE, and separately assert reset during CONFIG → IDLE next cycle with cfg_req=0 and format_out held. On reset, all outputs return to their reset values.

Source files
------------

// File: rtl/video_format_scheduler.sv
// Gated vsync/hsync measurement, format classification with N-window stability filter,
// and a req/ack commit of each format change to downstream mode-configuration logic.
module video_format_scheduler #(
  parameter int GATE_CYCLES     = 50000000,
  parameter int STABLE_COUNT    = 3,
  parameter int ACK_TIMEOUT     = 1000000,
  parameter int V50_MIN         = 45,
  parameter int V50_MAX         = 55,
  parameter int V60_MIN         = 56,
  parameter int V60_MAX         = 65,
  parameter int H_INTERLACE_MAX = 23000
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       hsync_in,
  input  logic       measure_en,
  input  logic       cfg_ack,
  output logic       cfg_req,
  output logic [7:0] cfg_format,
  output logic [7:0] format_out,
  output logic       locked,
  output logic [4:0] error_bits
);

  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, GATE = 3'd2, EVAL = 3'd3, CONFIG = 3'd4} state_t;

  state_t      state_q, state_d;
  logic [2:0]  vs_sh_q, vs_sh_d, hs_sh_q, hs_sh_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] vcnt_q, vcnt_d, hcnt_q, hcnt_d;
  logic [3:0]  stab_q, stab_d, stab_nx;
  logic [7:0]  prev_cand_q, prev_cand_d, cand;
  logic        cfg_req_q, cfg_req_d, locked_q, locked_d;
  logic [7:0]  cfg_format_q, cfg_format_d, format_q, format_d;
  logic [4:0]  err_q, err_d;
  logic        vs_edge, hs_edge, rate50, rate60, rate_ok, interlaced, stable;

  // Sync chain idles high so reset release never fakes a falling edge.
  assign vs_sh_d = {vs_sh_q[1:0], vsync_in};
  assign hs_sh_d = {hs_sh_q[1:0], hsync_in};
  assign vs_edge = vs_sh_q[2] & ~vs_sh_q[1];
  assign hs_edge = hs_sh_q[2] & ~hs_sh_q[1];

  assign rate50     = (vcnt_q >= 16'(V50_MIN)) && (vcnt_q <= 16'(V50_MAX));
  assign rate60     = (vcnt_q >= 16'(V60_MIN)) && (vcnt_q <= 16'(V60_MAX));
  assign rate_ok    = rate50 || rate60;
  assign interlaced = (hcnt_q <= 16'(H_INTERLACE_MAX));

  always_comb begin
    cand = 8'h00;
    if (rate_ok && hcnt_q != 16'd0) begin
      if (rate50) cand = interlaced ? 8'h01 : 8'h03;
      else        cand = interlaced ? 8'h02 : 8'h04;
    end
  end

  assign stab_nx = (cand != prev_cand_q) ? 4'd1 :
                   (stab_q >= 4'(STABLE_COUNT)) ? 4'(STABLE_COUNT) : stab_q + 4'd1;
  assign stable  = (stab_nx == 4'(STABLE_COUNT));

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    vcnt_d       = vcnt_q;
    hcnt_d       = hcnt_q;
    stab_d       = stab_q;
    prev_cand_d  = prev_cand_q;
    cfg_req_d    = cfg_req_q;
    cfg_format_d = cfg_format_q;
    format_d     = format_q;
    locked_d     = locked_q;
    err_d        = err_q;
    if (!measure_en) begin
      state_d    = IDLE;
      cfg_req_d  = 1'b0;
      stab_d     = 4'd0;
      err_d[4:3] = 2'b00;
      timer_d    = 32'd0;
      vcnt_d     = 16'd0;
      hcnt_d     = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = 32'd0;
          vcnt_d  = 16'd0;
          hcnt_d  = 16'd0;
          state_d = ARM;
        end
        ARM: begin
          timer_d = timer_q + 32'd1;
          vcnt_d  = 16'd0;
          hcnt_d  = 16'd0;
          if (vs_edge) begin
            state_d = GATE;
            timer_d = 32'd0;
          end else if (timer_q == 32'(GATE_CYCLES - 1)) begin
            state_d = EVAL;
          end
        end
        GATE: begin
          timer_d = timer_q + 32'd1;
          if (vs_edge) begin
            if (vcnt_q == 16'hFFFF) err_d[4] = 1'b1;
            else                    vcnt_d = vcnt_q + 16'd1;
          end
          if (hs_edge) begin
            if (hcnt_q == 16'hFFFF) err_d[4] = 1'b1;
            else                    hcnt_d = hcnt_q + 16'd1;
          end
          if (timer_q == 32'(GATE_CYCLES - 1)) state_d = EVAL;
        end
        EVAL: begin
          stab_d      = stab_nx;
          prev_cand_d = cand;
          err_d[0]    = (vcnt_q == 16'd0);
          err_d[1]    = (vcnt_q != 16'd0) && !rate_ok;
          err_d[2]    = rate_ok && (hcnt_q == 16'd0);
          locked_d    = stable && (cand == format_q) && (format_q != 8'h00);
          timer_d     = 32'd0;
          state_d     = ARM;
          if (stable && (cand != format_q) && !cfg_ack) begin
            state_d      = CONFIG;
            cfg_req_d    = 1'b1;
            cfg_format_d = cand;
          end
        end
        CONFIG: begin
          timer_d = timer_q + 32'd1;
          if (cfg_ack) begin
            format_d  = cfg_format_q;
            locked_d  = (cfg_format_q != 8'h00) && (stab_q == 4'(STABLE_COUNT)) &&
                        (prev_cand_q == cfg_format_q);
            cfg_req_d = 1'b0;
            timer_d   = 32'd0;
            state_d   = ARM;
          end else if (timer_q == 32'(ACK_TIMEOUT - 1)) begin
            // Give up this round; the next stable EVAL re-issues the request.
            cfg_req_d = 1'b0;
            err_d[3]  = 1'b1;
            timer_d   = 32'd0;
            state_d   = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz_in or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      vs_sh_q      <= 3'b111;
      hs_sh_q      <= 3'b111;
      timer_q      <= 32'd0;
      vcnt_q       <= 16'd0;
      hcnt_q       <= 16'd0;
      stab_q       <= 4'd0;
      prev_cand_q  <= 8'h00;
      cfg_req_q    <= 1'b0;
      cfg_format_q <= 8'h00;
      format_q     <= 8'h00;
      locked_q     <= 1'b0;
      err_q        <= 5'd0;
    end else begin
      state_q      <= state_d;
      vs_sh_q      <= vs_sh_d;
      hs_sh_q      <= hs_sh_d;
      timer_q      <= timer_d;
      vcnt_q       <= vcnt_d;
      hcnt_q       <= hcnt_d;
      stab_q       <= stab_d;
      prev_cand_q  <= prev_cand_d;
      cfg_req_q    <= cfg_req_d;
      cfg_format_q <= cfg_format_d;
      format_q     <= format_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign cfg_req    = cfg_req_q;
  assign cfg_format = cfg_format_q;
  assign format_out = format_q;
  assign locked     = locked_q;
  assign error_bits = err_q;

endmodule

// File: tb/tb_video_format_scheduler.sv
// Bench for video_format_scheduler: table of sync patterns plus hand sequences,
// with a request scoreboard fed from the stimulus side.
module tb_video_format_scheduler;
  localparam int GATE  = 1000;
  localparam int STAB  = 3;
  localparam int ACKTO = 50;
  localparam int HMAX  = 300;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       vsync = 1'b1, hsync = 1'b1, men = 1'b0, ack = 1'b0;
  logic       cfg_req, locked;
  logic [7:0] cfg_format, format_out;
  logic [4:0] error_bits;

  video_format_scheduler #(
    .GATE_CYCLES(GATE), .STABLE_COUNT(STAB), .ACK_TIMEOUT(ACKTO),
    .V50_MIN(45), .V50_MAX(55), .V60_MIN(56), .V60_MAX(65), .H_INTERLACE_MAX(HMAX)
  ) dut (
    .clk_50mhz_in(clk), .reset(rst_n), .vsync_in(vsync), .hsync_in(hsync),
    .measure_en(men), .cfg_ack(ack), .cfg_req(cfg_req), .cfg_format(cfg_format),
    .format_out(format_out), .locked(locked), .error_bits(error_bits)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int vper = 20, hper = 5, vc = 0, hc = 0, ack_cnt = 0;
  bit v_en = 1'b0, h_en = 1'b0, ack_mode = 1'b0;
  logic [7:0] exp_q[$];
  bit req_prev = 1'b0, hold_bad = 1'b0;
  logic [7:0] held = 8'h00;

  typedef struct {
    int         vp;
    int         hp;
    bit         ven;
    logic [7:0] fmt;
    logic [4:0] err;
    bit         lck;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active-low one-cycle sync pulses at the programmed periods.
  initial forever begin
    @(negedge clk);
    vc = (vc + 1 >= vper) ? 0 : vc + 1;
    hc = (hc + 1 >= hper) ? 0 : hc + 1;
    vsync = !(v_en && vc == 0);
    hsync = !(h_en && hc == 0);
  end

  // Downstream responder: level ack two cycles after req, released after req drops.
  initial forever begin
    @(negedge clk);
    if (ack_mode && cfg_req) begin
      ack_cnt++;
      if (ack_cnt >= 2) ack = 1'b1;
    end else if (!cfg_req) begin
      ack_cnt = 0;
      ack = 1'b0;
    end
  end

  // Scoreboard: every request must match the next expected format and hold steady.
  initial forever begin
    @(negedge clk);
    if (cfg_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: cfg_format=%0h with none expected", cfg_format);
      end else begin
        chk("req_format", 32'(cfg_format), 32'(exp_q.pop_front()));
      end
      held = cfg_format;
      hold_bad = 1'b0;
    end else if (cfg_req && req_prev && cfg_format !== held) begin
      hold_bad = 1'b1;
    end else if (!cfg_req && req_prev) begin
      chk("req_hold", 32'(hold_bad), 32'd0);
    end
    req_prev = cfg_req;
  end

  task automatic wait_state(input logic [2:0] st, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (dut.state_q == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fmt(input logic [7:0] f, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (format_out == f) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (cfg_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;
    tbl[0] = '{vp: 20, hp: 5, ven: 1'b1, fmt: 8'h01, err: 5'h00, lck: 1'b1};
    tbl[1] = '{vp: 17, hp: 3, ven: 1'b1, fmt: 8'h04, err: 5'h00, lck: 1'b1};
    tbl[2] = '{vp: 17, hp: 5, ven: 1'b1, fmt: 8'h02, err: 5'h00, lck: 1'b1};
    tbl[3] = '{vp: 20, hp: 3, ven: 1'b1, fmt: 8'h03, err: 5'h00, lck: 1'b1};
    tbl[4] = '{vp: 20, hp: 3, ven: 1'b0, fmt: 8'h00, err: 5'h01, lck: 1'b0};

    #1;
    chk("rst_cfg_req", 32'(cfg_req), 32'd0);
    chk("rst_cfg_format", 32'(cfg_format), 32'd0);
    chk("rst_format_out", 32'(format_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_error_bits", 32'(error_bits), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    h_en = 1'b1;
    ack_mode = 1'b1;
    men = 1'b1;

    for (int i = 0; i < 5; i++) begin
      vper = tbl[i].vp;
      hper = tbl[i].hp;
      v_en = tbl[i].ven;
      exp_q.push_back(tbl[i].fmt);
      wait_state(3'd3, 5000, ok);
      chk("eval_seen", 32'(ok), 32'd1);
      @(negedge clk);
      chk("lock_drop", 32'(locked), 32'd0);
      wait_fmt(tbl[i].fmt, ok);
      chk("commit_seen", 32'(ok), 32'd1);
      chk("format_out", 32'(format_out), 32'(tbl[i].fmt));
      chk("locked", 32'(locked), 32'(tbl[i].lck));
      chk("error_bits", 32'(error_bits), 32'(tbl[i].err));
    end

    // Alternating 50/60 Hz windows must never commit.
    v_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_state(3'd3, 5000, ok);
      chk("alt_eval_seen", 32'(ok), 32'd1);
      vper = (k % 2 == 0) ? 20 : 17;
      hper = (k % 2 == 0) ? 5 : 3;
    end
    chk("alt_format_out", 32'(format_out), 32'd0);
    chk("alt_locked", 32'(locked), 32'd0);
    chk("alt_error_bits", 32'(error_bits), 32'd0);

    // 576p50 with no ack: timeout, then retry gets acknowledged.
    ack_mode = 1'b0;
    vper = 20;
    hper = 3;
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h03);
    wait_req(ok);
    chk("to_req_seen", 32'(ok), 32'd1);
    n = 0;
    while (cfg_req && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_width", 32'(n), 32'(ACKTO));
    chk("to_err3", 32'(error_bits[3]), 32'd1);
    chk("to_format_held", 32'(format_out), 32'd0);
    ack_mode = 1'b1;
    wait_fmt(8'h03, ok);
    chk("retry_commit", 32'(ok), 32'd1);
    chk("retry_locked", 32'(locked), 32'd1);
    chk("retry_err", 32'(error_bits), 32'h08);

    // measure_en dropped mid-window.
    wait_state(3'd2, 3000, ok);
    chk("gate_seen", 32'(ok), 32'd1);
    repeat (100) @(negedge clk);
    men = 1'b0;
    @(negedge clk);
    chk("men_idle", 32'(dut.state_q), 32'd0);
    chk("men_cfg_req", 32'(cfg_req), 32'd0);
    chk("men_format_held", 32'(format_out), 32'h03);
    chk("men_locked_held", 32'(locked), 32'd1);
    chk("men_err_cleared", 32'(error_bits), 32'd0);

    // Reset asserted while a request is outstanding.
    ack_mode = 1'b0;
    vper = 17;
    hper = 3;
    exp_q.push_back(8'h04);
    men = 1'b1;
    wait_req(ok);
    chk("cfg_req_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_cfg_req", 32'(cfg_req), 32'd0);
    chk("arst_cfg_format", 32'(cfg_format), 32'd0);
    chk("arst_format_out", 32'(format_out), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_error_bits", 32'(error_bits), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
